// File: rtl/cic_decim_ctrl.sv
// cic_decim_ctrl: decimation sequencer between the last CIC integrator and the first comb stage.
// Define CIC_CTRL_WARMUP_EN to add the WARMUP state that suppresses unsettled comb outputs.
module cic_decim_ctrl #(
  parameter int SAMP_WIDTH    = 8,
  parameter int CIC_N         = 3,
  parameter int CIC_M         = 1,
  parameter int CIC_R_MAX     = 16,
  parameter int CIC_R_DEFAULT = 4,
  parameter int R_WIDTH       = $clog2(CIC_R_MAX + 1)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic signed [SAMP_WIDTH-1:0] samp_inp_data,
  input  logic                         samp_inp_str,
  input  logic        [R_WIDTH-1:0]    cfg_rate,
  input  logic                         cfg_load,
  output logic signed [SAMP_WIDTH-1:0] comb_inp_data,
  output logic                         comb_inp_str,
  output logic                         samp_out_str,
  output logic        [R_WIDTH-1:0]    cur_rate,
  output logic                         settled,
  output logic                         rate_err
);

  if (CIC_N < 1 || CIC_M < 1 || CIC_R_DEFAULT < 1 || CIC_R_DEFAULT > CIC_R_MAX) begin : g_bad_cfg
    $error("cic_decim_ctrl: illegal parameter set");
  end

  typedef enum logic [1:0] {StIdle, StWarmup, StRun} state_e;

`ifdef CIC_CTRL_WARMUP_EN
  localparam state_e StStart = StWarmup;
`else
  localparam state_e StStart = StRun;
`endif

  state_e                         state_q, state_d;
  logic          [R_WIDTH-1:0]    dec_cnt_q, dec_cnt_d;
  logic          [R_WIDTH-1:0]    cur_rate_q, cur_rate_d;
  logic          [R_WIDTH-1:0]    pend_rate_q, pend_rate_d;
  logic                           pend_vld_q, pend_vld_d;
  logic                           comb_str_q, comb_str_d;
  logic signed   [SAMP_WIDTH-1:0] comb_data_q, comb_data_d;
  logic                           rate_err_q, rate_err_d;
  logic          [CIC_N-1:0]      lat_q, lat_d;

  logic               active, load_ok, wrap, apply, warm_done, qual;
  logic [R_WIDTH-1:0] apply_rate;

  assign active     = (state_q != StIdle);
  assign load_ok    = cfg_load && (cfg_rate != '0) && (cfg_rate <= R_WIDTH'(CIC_R_MAX));
  assign wrap       = active && samp_inp_str && (dec_cnt_q == cur_rate_q - R_WIDTH'(1));
  // A load landing on the wrap itself takes effect immediately, ahead of any older pending rate.
  assign apply      = wrap && enable && (load_ok || pend_vld_q);
  assign apply_rate = load_ok ? cfg_rate : pend_rate_q;

`ifdef CIC_CTRL_WARMUP_EN
  localparam int unsigned WarmLen = CIC_N * CIC_M;
  localparam int unsigned WarmW   = $clog2(WarmLen + 1);

  logic [WarmW-1:0] warm_cnt_q, warm_cnt_d;

  always_comb begin
    warm_cnt_d = warm_cnt_q;
    if (state_q == StIdle || !enable || apply) begin
      warm_cnt_d = '0;
    end else if (state_q == StWarmup && comb_str_q && !warm_done) begin
      warm_cnt_d = warm_cnt_q + WarmW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) warm_cnt_q <= '0;
    else          warm_cnt_q <= warm_cnt_d;
  end

  assign warm_done = (warm_cnt_q == WarmW'(WarmLen));
  // Strobes issued before the chain has seen a full warm-up never qualify, even if RUN comes first.
  assign qual      = warm_done;
`else
  assign warm_done = 1'b0;
  assign qual      = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StStart;
      end
      StWarmup: begin
        if (!enable)        state_d = StIdle;
        else if (apply)     state_d = StWarmup;
        else if (warm_done) state_d = StRun;
      end
      StRun: begin
        if (!enable)    state_d = StIdle;
        else if (apply) state_d = StStart;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state
  always_comb begin
    dec_cnt_d   = dec_cnt_q;
    cur_rate_d  = cur_rate_q;
    pend_rate_d = pend_rate_q;
    pend_vld_d  = pend_vld_q;
    comb_str_d  = wrap;
    comb_data_d = wrap ? samp_inp_data : comb_data_q;
    rate_err_d  = cfg_load && !load_ok;
    lat_d       = CIC_N'({lat_q, comb_str_q && qual});

    if (!active) begin
      dec_cnt_d  = '0;
      pend_vld_d = 1'b0;
      if (load_ok) cur_rate_d = cfg_rate;
    end else if (!enable) begin
      dec_cnt_d  = '0;
      pend_vld_d = 1'b0;
    end else if (wrap) begin
      dec_cnt_d = '0;
      if (apply) begin
        cur_rate_d = apply_rate;
        pend_vld_d = 1'b0;
      end
    end else begin
      if (samp_inp_str) dec_cnt_d = dec_cnt_q + R_WIDTH'(1);
      if (load_ok) begin
        pend_vld_d  = 1'b1;
        pend_rate_d = cfg_rate;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dec_cnt_q   <= '0;
      cur_rate_q  <= R_WIDTH'(CIC_R_DEFAULT);
      pend_rate_q <= '0;
      pend_vld_q  <= 1'b0;
      comb_str_q  <= 1'b0;
      comb_data_q <= '0;
      rate_err_q  <= 1'b0;
      lat_q       <= '0;
    end else begin
      dec_cnt_q   <= dec_cnt_d;
      cur_rate_q  <= cur_rate_d;
      pend_rate_q <= pend_rate_d;
      pend_vld_q  <= pend_vld_d;
      comb_str_q  <= comb_str_d;
      comb_data_q <= comb_data_d;
      rate_err_q  <= rate_err_d;
      lat_q       <= lat_d;
    end
  end

  // Outputs
  always_comb begin
    settled       = (state_q == StRun);
    samp_out_str  = lat_q[CIC_N-1] && (state_q == StRun);
    comb_inp_str  = comb_str_q;
    comb_inp_data = comb_data_q;
    cur_rate      = cur_rate_q;
    rate_err      = rate_err_q;
  end

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// tb_cic_decim_ctrl: randomized bench for cic_decim_ctrl against a transaction-level model
// (input counting per period, queue of expected output strobes with their release times).
module tb_cic_decim_ctrl;

  localparam int SW   = 8;
  localparam int N    = 3;
  localparam int M    = 1;
  localparam int RMAX = 16;
  localparam int RDEF = 4;
  localparam int RW   = $clog2(RMAX + 1);
  localparam int NM   = N * M;
`ifdef CIC_CTRL_WARMUP_EN
  localparam bit WarmEn = 1'b1;
`else
  localparam bit WarmEn = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 enable = 1'b0;
  logic signed [SW-1:0] samp_inp_data = '0;
  logic                 samp_inp_str = 1'b0;
  logic        [RW-1:0] cfg_rate = '0;
  logic                 cfg_load = 1'b0;
  logic signed [SW-1:0] comb_inp_data;
  logic                 comb_inp_str;
  logic                 samp_out_str;
  logic        [RW-1:0] cur_rate;
  logic                 settled;
  logic                 rate_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cic_decim_ctrl #(
    .SAMP_WIDTH   (SW),
    .CIC_N        (N),
    .CIC_M        (M),
    .CIC_R_MAX    (RMAX),
    .CIC_R_DEFAULT(RDEF)
  ) u_dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .samp_inp_data(samp_inp_data),
    .samp_inp_str (samp_inp_str),
    .cfg_rate     (cfg_rate),
    .cfg_load     (cfg_load),
    .comb_inp_data(comb_inp_data),
    .comb_inp_str (comb_inp_str),
    .samp_out_str (samp_out_str),
    .cur_rate     (cur_rate),
    .settled      (settled),
    .rate_err     (rate_err)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle model time %0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int cyc;
  bit m_run, m_settled, m_str, m_err;
  int m_cnt, m_rate, m_pend, m_issued, m_settle_at, m_data;
  int q_time[$];
  bit q_qual[$];

  task automatic model_reset();
    m_run = 0; m_settled = 0; m_str = 0; m_err = 0;
    m_cnt = 0; m_rate = RDEF; m_pend = 0; m_issued = 0; m_settle_at = -1; m_data = 0;
    q_time.delete();
    q_qual.delete();
  endtask

  task automatic model_step(input bit en, input bit str, input int data, input bit ld,
                            input int rate);
    bit ok, wrap, apply, qual;
    ok    = ld && rate >= 1 && rate <= RMAX;
    m_err = ld && !ok;
    m_str = 0;
    if (m_run) begin
      if (WarmEn && m_settle_at == cyc) m_settled = 1;
      wrap = 0;
      if (str) begin
        m_cnt++;
        if (m_cnt == m_rate) begin
          wrap  = 1;
          m_cnt = 0;
        end
      end
      if (wrap) begin
        m_str  = 1;
        m_data = data;
        apply  = en && (ok || m_pend != 0);
        if (apply) begin
          m_rate      = ok ? rate : m_pend;
          m_pend      = 0;
          m_issued    = 0;
          m_settle_at = -1;
          m_settled   = 0;
        end
        qual = WarmEn ? (en && m_issued >= NM) : 1'b1;
        q_time.push_back(cyc + N);
        q_qual.push_back(qual);
        m_issued++;
        if (WarmEn && m_issued == NM) m_settle_at = cyc + 2;
      end else if (ok) begin
        m_pend = rate;
      end
      if (!en) begin
        m_run = 0; m_cnt = 0; m_pend = 0; m_issued = 0; m_settled = 0; m_settle_at = -1;
      end
    end else begin
      if (ok) m_rate = rate;
      if (en) begin
        m_run = 1; m_cnt = 0; m_issued = 0; m_settle_at = -1; m_settled = 0;
      end
    end
  endtask

  task automatic compare();
    bit exp_out;
    bit exp_set;
    exp_set = WarmEn ? m_settled : m_run;
    exp_out = 0;
    if (q_time.size() > 0 && q_time[0] == cyc) begin
      exp_out = q_qual[0] && exp_set;
      void'(q_time.pop_front());
      void'(q_qual.pop_front());
    end
    check_eq("comb_inp_str", int'(comb_inp_str), int'(m_str));
    check_eq("comb_inp_data", int'(comb_inp_data), m_data);
    check_eq("samp_out_str", int'(samp_out_str), int'(exp_out));
    check_eq("settled", int'(settled), int'(exp_set));
    check_eq("cur_rate", int'(cur_rate), m_rate);
    check_eq("rate_err", int'(rate_err), int'(m_err));
  endtask

  task automatic cycle(input bit en, input bit str, input int data, input bit ld, input int rate);
    logic signed [SW-1:0] d8;
    d8 = data[SW-1:0];
    @(negedge clk);
    enable        = en;
    samp_inp_str  = str;
    samp_inp_data = d8;
    cfg_load      = ld;
    cfg_rate      = rate[RW-1:0];
    @(posedge clk);
    cyc++;
    model_step(en, str, int'(d8), ld, rate);
    #1;
    compare();
  endtask

  task automatic reset_mid();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rst_comb_inp_str", int'(comb_inp_str), 0);
    check_eq("rst_comb_inp_data", int'(comb_inp_data), 0);
    check_eq("rst_samp_out_str", int'(samp_out_str), 0);
    check_eq("rst_settled", int'(settled), 0);
    check_eq("rst_rate_err", int'(rate_err), 0);
    check_eq("rst_cur_rate", int'(cur_rate), RDEF);
    enable = 1'b0; samp_inp_str = 1'b0; cfg_load = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    cyc = 0;
    model_reset();
    reset_mid();

    // R=4, continuous strobes, data 1,2,3..: captures 4,8,12..
    cycle(1, 0, 0, 0, 0);
    for (int i = 1; i <= 40; i++) cycle(1, 1, i, 0, 0);
    // Rate 2 requested mid-period
    cycle(1, 1, 41, 1, 2);
    for (int i = 42; i <= 70; i++) cycle(1, 1, i, 0, 0);
    // Illegal rates
    cycle(1, 1, 71, 1, 0);
    cycle(1, 1, 72, 1, 17);
    for (int i = 73; i <= 90; i++) cycle(1, 1, i, 0, 0);
    // Back to R=4, then enable dropped mid-period
    cycle(1, 1, 91, 1, 4);
    for (int i = 92; i <= 110; i++) cycle(1, 1, i, 0, 0);
    for (int i = 111; i <= 114; i++) cycle(0, 1, i, 0, 0);
    for (int i = 115; i <= 127; i++) cycle(1, 1, i, 0, 0);
    // R=1: every strobe forwarded
    cycle(1, 1, -5, 1, 1);
    for (int i = 0; i < 20; i++) cycle(1, 1, -i, 0, 0);
    reset_mid();

    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0, int'($urandom),
            $urandom_range(0, 15) == 0, $urandom_range(0, 18));
      if (i == 2000) reset_mid();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
